// File: rtl/rr_arb4_dec.sv
// Four-way round-robin arbiter driving a 2:4 decoder: registered select pair plus
// active-low one-hot strobes, with a dead gap after every release. Optional macro: ARB_TIMEOUT_EN.
module rr_arb4_dec #(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       sel_a,
    output logic       sel_b,
    output logic [3:0] gnt_n,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] gnt_n_q, gnt_n_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    // Candidate k is requester (ptr+k) mod 4; the lowest requesting k wins.
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic [1:0] winner;

    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
        assign cand_idx[gi] = ptr_q + 2'(gi);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        winner = cand_idx[0];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        gnt_n_d   = gnt_n_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_d = ST_GRANT;
                    idx_d   = winner;
                    gnt_n_d = ~(4'b0001 << winner);
                    busy_d  = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!req[idx_q]) begin
                    state_d = ST_GAP;
                    gnt_n_d = 4'b1111;
                    busy_d  = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    gap_d   = GAP_LAST;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    // Owner still requesting at the limit: revoke as if it had released.
                    state_d   = ST_GAP;
                    gnt_n_d   = 4'b1111;
                    busy_d    = 1'b0;
                    ptr_d     = idx_q + 2'd1;
                    gap_d     = GAP_LAST;
                    timeout_d = 1'b1;
                end
`endif
                else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_n_d = 4'b1111;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            hold_q    <= 8'd0;
            gap_q     <= 4'd0;
            gnt_n_q   <= 4'b1111;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            gnt_n_q   <= gnt_n_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel_a   = idx_q[1];
    assign sel_b   = idx_q[0];
    assign gnt_n   = gnt_n_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
